// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver (8E1/8O1), valid/ack output, optional UART_RX_MAJORITY_VOTE_EN
module uart_rx_oversampled #(
    parameter int OS_DIV     = 325,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_bit_error,
    output logic       overrun_error,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] TICK_MAX = 16'(OS_DIV - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] SC_DECIDE = 4'd8;
`else
    localparam logic [3:0] SC_DECIDE = 4'd7;
`endif

    state_t      state, state_next;
    logic        rx_meta, rs, rs_prev;
    logic [15:0] tcnt;
    logic [3:0]  sc;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        perr;
    logic        tick, fall, start_det, decide, bit_val, complete;

    assign tick      = (tcnt == TICK_MAX);
    assign fall      = rs_prev & ~rs;
    assign start_det = (state == S_IDLE) & fall;
    assign decide    = tick & (sc == SC_DECIDE);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic v6, v7;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v6 <= 1'b1;
            v7 <= 1'b1;
        end else if (tick) begin
            if (sc == 4'd6) v6 <= rs;
            if (sc == 4'd7) v7 <= rs;
        end
    end

    assign bit_val = (v6 & v7) | (v6 & rs) | (v7 & rs);
`else
    assign bit_val = rs;
`endif

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            S_IDLE:   if (fall) state_next = S_START;
            S_START:  if (decide) state_next = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (decide && bit_idx == 3'd7) state_next = S_PARITY;
            S_PARITY: if (decide) state_next = S_STOP;
            S_STOP: begin
                if (decide) begin
                    state_next = S_IDLE;
                    complete   = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
            tcnt    <= '0;
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            rx_meta <= rx_in;
            rs      <= rx_meta;
            rs_prev <= rs;
            rx_busy <= (state_next != S_IDLE);
            // Restarting the tick phase on the edge puts sc == 7 at mid-bit.
            if (start_det || tick) tcnt <= '0;
            else                   tcnt <= tcnt + 16'd1;
            if (start_det)  sc <= '0;
            else if (tick)  sc <= sc + 4'd1;
            if (decide) begin
                case (state)
                    S_START:  bit_idx <= '0;
                    S_DATA: begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    S_PARITY: perr <= (^shreg) ^ bit_val ^ PARITY_ODD;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            parity_error   <= 1'b0;
            stop_bit_error <= 1'b0;
            overrun_error  <= 1'b0;
        end else if (complete) begin
            rx_data        <= shreg;
            parity_error   <= perr;
            stop_bit_error <= ~bit_val;
            rx_valid       <= 1'b1;
            // An ack in the same cycle frees the slot, so only an unacked held byte overruns.
            if (rx_valid && !rx_ack) overrun_error <= 1'b1;
        end else if (rx_ack && rx_valid) begin
            rx_valid      <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - self-checking bench for uart_rx_oversampled at OS_DIV = 4
module tb_uart_rx_oversampled;

    localparam int OS  = 4;
    localparam int BIT = 16 * OS;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int EXP_LAT = 3 + OS * 169;
`else
    localparam int EXP_LAT = 3 + OS * 168;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, stop_bit_error, overrun_error, rx_busy;

    uart_rx_oversampled #(.OS_DIV(OS), .PARITY_ODD(1'b0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_in          (rx_in),
        .rx_ack         (rx_ack),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_error   (parity_error),
        .stop_bit_error (stop_bit_error),
        .overrun_error  (overrun_error),
        .rx_busy        (rx_busy)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Expected receiver state in terms of frames delivered and acks given.
    logic       chk_en = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_perr = 1'b0;
    logic       m_serr = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic pbit, input logic sbit);
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = b;
        m_perr  = (^b) ^ pbit;
        m_serr  = ~sbit;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pbit, input logic sbit, input int spike_bit);
        logic [10:0] bits;
        bits   = {sbit, pbit, b, 1'b0};
        chk_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            if (i == spike_bit) begin
                idle(8 * OS - OS / 2);
                rx_in = 1'b0;
                idle(OS);
                rx_in = bits[i];
                idle(8 * OS - OS / 2);
            end else begin
                idle(BIT);
            end
        end
        rx_in = 1'b1;
        idle(8);
        model_frame(b, pbit, sbit);
        chk_en = 1'b1;
    endtask

    task automatic ack();
        chk_en = 1'b0;
        rx_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        chk_en = 1'b1;
    endtask

    always @(negedge clock) begin
        if (chk_en && reset_n) begin
            check("cmp_valid", {31'd0, rx_valid}, {31'd0, m_valid});
            check("cmp_overrun", {31'd0, overrun_error}, {31'd0, m_ovr});
            check("cmp_busy_idle", {31'd0, rx_busy}, 32'd0);
            if (m_valid) begin
                check("cmp_data", {24'd0, rx_data}, {24'd0, m_data});
                check("cmp_parity_err", {31'd0, parity_error}, {31'd0, m_perr});
                check("cmp_stop_err", {31'd0, stop_bit_error}, {31'd0, m_serr});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_perr"}, {31'd0, parity_error}, 32'd0);
        check({tag, "_serr"}, {31'd0, stop_bit_error}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun_error}, 32'd0);
        check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        logic [7:0] f0;
        reset_n = 1'b0;
        rx_in   = 1'b1;
        rx_ack  = 1'b0;
        idle(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(20);
        chk_en = 1'b1;

        // 0xA5, even parity 0, good stop; also measure start-edge-to-valid latency
        lat  = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, -1);
            begin
                while (!seen && lat < 4 * EXP_LAT) begin
                    @(posedge clock);
                    lat++;
                    #1;
                    if (rx_valid) seen = 1'b1;
                end
            end
        join
        check("latency_clocks", lat, EXP_LAT);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_perr", {31'd0, parity_error}, 32'd0);
        check("a5_serr", {31'd0, stop_bit_error}, 32'd0);
        ack();
        check("a5_ack_valid", {31'd0, rx_valid}, 32'd0);

        // 0x3C with the parity bit flipped
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        check("3c_data", {24'd0, rx_data}, 32'h3C);
        check("3c_perr", {31'd0, parity_error}, 32'd1);
        ack();

        // 0x81 with stop low, then a clean 0x55
        send_frame(8'h81, 1'b0, 1'b0, -1);
        check("81_serr", {31'd0, stop_bit_error}, 32'd1);
        check("81_data", {24'd0, rx_data}, 32'h81);
        ack();
        idle(BIT);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        check("55_data", {24'd0, rx_data}, 32'h55);
        check("55_serr", {31'd0, stop_bit_error}, 32'd0);
        check("55_perr", {31'd0, parity_error}, 32'd0);
        ack();

        // 3-tick low glitch: false start
        chk_en = 1'b0;
        rx_in  = 1'b0;
        idle(3);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        idle(3 * OS - 3);
        rx_in = 1'b1;
        idle(BIT);
        check("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk_en = 1'b1;

        // Overrun: two frames without ack
        send_frame(8'h11, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        check("ovr_data", {24'd0, rx_data}, 32'h22);
        check("ovr_flag", {31'd0, overrun_error}, 32'd1);
        ack();
        check("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, overrun_error}, 32'd0);

        // Break: line low for a whole frame, left unacked
        send_frame(8'h00, 1'b0, 1'b0, -1);
        check("break_data", {24'd0, rx_data}, 32'h00);
        check("break_serr", {31'd0, stop_bit_error}, 32'd1);
        check("break_valid", {31'd0, rx_valid}, 32'd1);

        // Reset pulsed half way through data bit 4 of 0xF0
        chk_en = 1'b0;
        f0     = 8'hF0;
        rx_in  = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_in = f0[i];
            idle(BIT);
        end
        rx_in = f0[4];
        idle(BIT / 2);
        check("midframe_busy", {31'd0, rx_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        idle(3);
        rx_in = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(BIT);
        chk_en = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b1, -1);
        check("0f_data", {24'd0, rx_data}, 32'h0F);
        check("0f_valid", {31'd0, rx_valid}, 32'd1);
        check("0f_ovr", {31'd0, overrun_error}, 32'd0);
        ack();

`ifdef UART_RX_MAJORITY_VOTE_EN
        // 1-tick low spike centred on data bit 1 (high) of 0x5A
        send_frame(8'h5A, 1'b0, 1'b1, 2);
        check("vote_data", {24'd0, rx_data}, 32'h5A);
        check("vote_perr", {31'd0, parity_error}, 32'd0);
        ack();
`endif

        idle(10);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
